// File: rtl/insn_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its
// immediate reader; prefix decode is only referenced when INSN_FETCH_PREFIX_EN is defined.
package insn_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_OP_FETCH, S_OP_DATA, S_MODRM, S_IMMED, S_DONE
  } fetch_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_POP0, R_CAP0, R_POP1, R_CAP1, R_DONE
  } reader_state_t;

  localparam logic [1:0] SEG_ES = 2'd0;
  localparam logic [1:0] SEG_CS = 2'd1;
  localparam logic [1:0] SEG_SS = 2'd2;
  localparam logic [1:0] SEG_DS = 2'd3;

  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  typedef struct packed {
    logic       seg;
    logic [1:0] seg_id;
    logic       lock;
    logic [1:0] rep;
  } prefix_info_t;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

  function automatic prefix_info_t decode_prefix(input logic [7:0] b);
    prefix_info_t p;
    p = '0;
    case (b)
      PFX_ES:    begin p.seg = 1'b1; p.seg_id = SEG_ES; end
      PFX_CS:    begin p.seg = 1'b1; p.seg_id = SEG_CS; end
      PFX_SS:    begin p.seg = 1'b1; p.seg_id = SEG_SS; end
      PFX_DS:    begin p.seg = 1'b1; p.seg_id = SEG_DS; end
      PFX_LOCK:  p.lock = 1'b1;
      PFX_REPNE: p.rep = 2'b10;
      PFX_REP:   p.rep = 2'b11;
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/insn_fetch_sequencer_immediate_reader.sv
// Reads a little-endian 8- or 16-bit value from the FIFO; 8-bit values are
// sign-extended. Pops in the start cycle; complete pulses after the last capture.
module insn_fetch_sequencer_immediate_reader
  import insn_fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_8bit,
  input  logic        abort,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        busy,
  output logic        complete,
  output logic [15:0] immediate
);

  reader_state_t state, state_nxt;
  logic          is8_q;
  logic [15:0]   value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= R_IDLE;
      is8_q   <= 1'b0;
      value_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == R_IDLE && start) is8_q <= is_8bit;
      if (state == R_CAP0) value_q <= is8_q ? sext8(fifo_rd_data) : {8'h00, fifo_rd_data};
      if (state == R_CAP1) value_q[15:8] <= fifo_rd_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      R_IDLE: if (start) begin
        fifo_rd_en = ~fifo_empty;
        state_nxt  = fifo_empty ? R_POP0 : R_CAP0;
      end
      R_POP0: begin
        fifo_rd_en = ~fifo_empty;
        if (!fifo_empty) state_nxt = R_CAP0;
      end
      // high byte is popped in the same cycle the low byte is captured
      R_CAP0: if (is8_q) state_nxt = R_DONE;
      else begin
        fifo_rd_en = ~fifo_empty;
        state_nxt  = fifo_empty ? R_POP1 : R_CAP1;
      end
      R_POP1: begin
        fifo_rd_en = ~fifo_empty;
        if (!fifo_empty) state_nxt = R_CAP1;
      end
      R_CAP1:  state_nxt = R_DONE;
      R_DONE:  state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
    if (abort) state_nxt = R_IDLE;
  end

  assign busy      = (state != R_IDLE);
  assign complete  = (state == R_DONE);
  assign immediate = value_q;

endmodule

// File: rtl/insn_fetch_sequencer.sv
// Fetch sequencer: prefixes (INSN_FETCH_PREFIX_EN), opcode, ModRM handoff,
// displacement and data immediate, arbitrating the single FIFO read port.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_OP_FETCH | popping the opcode (or next prefix) byte
// S_OP_DATA  | opcode byte on fifo_rd_data, dispatch on descriptor
// S_MODRM    | ModRM decoder owns the port, displacement via reader
// S_IMMED    | reader fetching the data immediate
// S_DONE     | insn_complete pulse
module insn_fetch_sequencer
  import insn_fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic [7:0]  opcode,
  input  logic        desc_has_modrm,
  input  logic        desc_has_imm,
  input  logic        desc_imm_is_8bit,
  output logic        modrm_start,
  output logic        modrm_clear,
  input  logic        modrm_complete,
  input  logic        modrm_fifo_rd_en,
  input  logic        modrm_immed_start,
  input  logic        modrm_immed_is_8bit,
  output logic        modrm_immed_complete,
  output logic [15:0] displacement,
  output logic [15:0] immediate,
  output logic        insn_complete,
  output logic        busy
`ifdef INSN_FETCH_PREFIX_EN
  ,
  output logic        seg_override_valid,
  output logic [1:0]  seg_override,
  output logic        lock,
  output logic [1:0]  rep
`endif
);

  fetch_state_t state, state_nxt;
  logic [7:0]   opcode_q;
  logic [15:0]  disp_q, imm_q;
  logic         disp_done, imm_started;
  logic         disp_start, imm_start, prefix_hit;
  logic         rdr_start, rdr_is_8bit, rdr_rd_en, rdr_busy, rdr_complete;
  logic [15:0]  rdr_value;

  assign disp_start  = (state == S_MODRM) & modrm_immed_start & ~disp_done & ~rdr_busy & ~flush;
  assign imm_start   = (state == S_IMMED) & ~imm_started & ~rdr_busy & ~flush;
  assign rdr_start   = disp_start | imm_start;
  assign rdr_is_8bit = (state == S_MODRM) ? modrm_immed_is_8bit : desc_imm_is_8bit;

  insn_fetch_sequencer_immediate_reader u_reader (
    .clk          (clk),
    .reset        (reset),
    .start        (rdr_start),
    .is_8bit      (rdr_is_8bit),
    .abort        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (rdr_rd_en),
    .busy         (rdr_busy),
    .complete     (rdr_complete),
    .immediate    (rdr_value)
  );

`ifdef INSN_FETCH_PREFIX_EN
  prefix_info_t pfx;
  assign pfx        = decode_prefix(fifo_rd_data);
  assign prefix_hit = pfx.seg | pfx.lock | (|pfx.rep);
`else
  assign prefix_hit = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    fifo_rd_en    = 1'b0;
    modrm_start   = 1'b0;
    insn_complete = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        fifo_rd_en = ~fifo_empty & ~flush;
        state_nxt  = fifo_empty ? S_OP_FETCH : S_OP_DATA;
      end
      S_OP_FETCH: begin
        fifo_rd_en = ~fifo_empty;
        if (!fifo_empty) state_nxt = S_OP_DATA;
      end
      S_OP_DATA: begin
        if (prefix_hit)          state_nxt = S_OP_FETCH;
        else if (desc_has_modrm) state_nxt = S_MODRM;
        else if (desc_has_imm)   state_nxt = S_IMMED;
        else                     state_nxt = S_DONE;
      end
      // the reader takes the port from the decoder while fetching the displacement
      S_MODRM: begin
        modrm_start = 1'b1;
        fifo_rd_en  = (rdr_busy | rdr_start) ? rdr_rd_en : (modrm_fifo_rd_en & ~fifo_empty);
        if (modrm_complete) state_nxt = desc_has_imm ? S_IMMED : S_DONE;
      end
      S_IMMED: begin
        fifo_rd_en = rdr_rd_en;
        if (imm_started && rdr_complete) state_nxt = S_DONE;
      end
      S_DONE: begin
        insn_complete = ~flush;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      opcode_q    <= '0;
      disp_q      <= '0;
      imm_q       <= '0;
      disp_done   <= 1'b0;
      imm_started <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_OP_DATA) begin
        opcode_q <= fifo_rd_data;
        disp_q   <= '0;
        imm_q    <= '0;
      end
      if (modrm_immed_complete) disp_q <= rdr_value;
      if (state == S_IMMED && imm_started && rdr_complete && !flush) imm_q <= rdr_value;
      if (flush || state == S_DONE || state == S_IDLE) disp_done <= 1'b0;
      else if (modrm_immed_complete)                   disp_done <= 1'b1;
      if (flush || state != S_IMMED) imm_started <= 1'b0;
      else if (imm_start)            imm_started <= 1'b1;
    end
  end

`ifdef INSN_FETCH_PREFIX_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_override_valid <= 1'b0;
      seg_override       <= SEG_ES;
      lock               <= 1'b0;
      rep                <= 2'b00;
    end else if (state == S_IDLE && start && !flush) begin
      seg_override_valid <= 1'b0;
      seg_override       <= SEG_ES;
      lock               <= 1'b0;
      rep                <= 2'b00;
    end else if (state == S_OP_DATA && !flush) begin
      if (pfx.seg) begin
        seg_override_valid <= 1'b1;
        seg_override       <= pfx.seg_id;
      end
      if (pfx.lock)  lock <= 1'b1;
      if (|pfx.rep)  rep  <= pfx.rep;
    end
  end
`endif

  assign opcode               = (state == S_OP_DATA) ? fifo_rd_data : opcode_q;
  assign displacement         = disp_q;
  assign immediate            = imm_q;
  assign modrm_clear          = flush;
  assign modrm_immed_complete = (state == S_MODRM) & rdr_complete & ~flush;
  assign busy                 = (state != S_IDLE) | start;

endmodule

// File: tb/tb_insn_fetch_sequencer.sv
// Self-checking bench: byte-FIFO model, opcode descriptor table, inline ModRM
// decoder model and an expected-result scoreboard popped on insn_complete.
module tb_insn_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty;
  logic [7:0]  opcode;
  logic        desc_has_modrm, desc_has_imm, desc_imm_is_8bit;
  logic        modrm_start, modrm_clear;
  logic        modrm_complete = 1'b0;
  logic        modrm_fifo_rd_en = 1'b0;
  logic        modrm_immed_start = 1'b0;
  logic        modrm_immed_is_8bit = 1'b0;
  logic        modrm_immed_complete;
  logic [15:0] displacement, immediate;
  logic        insn_complete, busy;
`ifdef INSN_FETCH_PREFIX_EN
  logic        seg_override_valid, lock;
  logic [1:0]  seg_override, rep;
`endif

  logic [7:0]  mem [0:63];
  logic [5:0]  wr_ptr = 6'd0;
  logic [5:0]  rd_ptr = 6'd0;
  int          cyc = 0, pops = 0, bad_pops = 0;
  int          errors = 0, checks = 0, t0 = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] disp;
    logic [15:0] imm;
    int          lat;
  } exp_t;
  exp_t sb[$];

  insn_fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .opcode(opcode), .desc_has_modrm(desc_has_modrm), .desc_has_imm(desc_has_imm),
    .desc_imm_is_8bit(desc_imm_is_8bit), .modrm_start(modrm_start), .modrm_clear(modrm_clear),
    .modrm_complete(modrm_complete), .modrm_fifo_rd_en(modrm_fifo_rd_en),
    .modrm_immed_start(modrm_immed_start), .modrm_immed_is_8bit(modrm_immed_is_8bit),
    .modrm_immed_complete(modrm_immed_complete), .displacement(displacement),
    .immediate(immediate), .insn_complete(insn_complete), .busy(busy)
`ifdef INSN_FETCH_PREFIX_EN
    , .seg_override_valid(seg_override_valid), .seg_override(seg_override),
    .lock(lock), .rep(rep)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_empty       = (rd_ptr == wr_ptr);
  assign desc_has_modrm   = (opcode == 8'h8B);
  assign desc_has_imm     = (opcode == 8'hB8) || (opcode == 8'h04);
  assign desc_imm_is_8bit = (opcode == 8'h04);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      if (fifo_empty) bad_pops <= bad_pops + 1;
      else begin
        fifo_rd_data <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 6'd1;
        pops         <= pops + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  function automatic exp_t mk_exp(input logic [7:0] op, input logic [15:0] disp,
                                  input logic [15:0] imm, input int lat);
    exp_t e;
    e.op = op; e.disp = disp; e.imm = imm; e.lat = lat;
    return e;
  endfunction

  task automatic begin_insn();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    #1;
  endtask

  task automatic wait_insn(input int limit, output bit got, output int lat);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (insn_complete === 1'b1) begin
        got = 1'b1;
        lat = cyc - t0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({fifo_rd_en, modrm_start, modrm_clear, modrm_immed_complete, insn_complete, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000",
        {fifo_rd_en, modrm_start, modrm_clear, modrm_immed_complete, insn_complete, busy});
    end
    checks++;
    if (opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode: got %h want 00", opcode); end
    checks++;
    if (displacement !== 16'h0) begin errors++; $display("FAIL reset_disp: got %h want 0000", displacement); end
    checks++;
    if (immediate !== 16'h0) begin errors++; $display("FAIL reset_imm: got %h want 0000", immediate); end
`ifdef INSN_FETCH_PREFIX_EN
    checks++;
    if ({seg_override_valid, seg_override, lock, rep} !== 6'b0) begin
      errors++; $display("FAIL reset_prefix: got %b want 000000", {seg_override_valid, seg_override, lock, rep});
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_opcode_only();
    bit got; int lat; exp_t e;
    push(8'h90);
    sb.push_back(mk_exp(8'h90, 16'h0, 16'h0, 2));
    begin_insn();
    checks++;
    if ({fifo_rd_en, busy} !== 2'b11) begin errors++; $display("FAIL op_only_c0: got rd_en,busy=%b want 11", {fifo_rd_en, busy}); end
    wait_insn(20, got, lat);
    e = sb.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL op_only_done: got no insn_complete want pulse"); end
    else begin
      checks++;
      if ({opcode, displacement, immediate} !== {e.op, e.disp, e.imm}) begin
        errors++; $display("FAIL op_only_result: got %h/%h/%h want %h/%h/%h", opcode, displacement, immediate, e.op, e.disp, e.imm);
      end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL op_only_latency: got %0d want %0d", lat, e.lat); end
    end
    @(negedge clk); #1;
    checks++;
    if ({busy, insn_complete} !== 2'b00) begin errors++; $display("FAIL op_only_idle: got busy,done=%b want 00", {busy, insn_complete}); end
  endtask

  task automatic test_imm16();
    bit got; int lat, p0; exp_t e;
    push(8'hB8); push(8'h34); push(8'h12);
    p0 = pops;
    sb.push_back(mk_exp(8'hB8, 16'h0, 16'h1234, 6));
    begin_insn();
    wait_insn(30, got, lat);
    e = sb.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL imm16_done: got no insn_complete want pulse"); end
    else begin
      checks++;
      if ({opcode, displacement, immediate} !== {e.op, e.disp, e.imm}) begin
        errors++; $display("FAIL imm16_result: got %h/%h/%h want %h/%h/%h", opcode, displacement, immediate, e.op, e.disp, e.imm);
      end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL imm16_latency: got %0d want %0d", lat, e.lat); end
    end
    @(negedge clk); #1;
    checks++;
    if (pops - p0 != 3) begin errors++; $display("FAIL imm16_pops: got %0d want 3", pops - p0); end
    checks++;
    if (immediate !== 16'h1234) begin errors++; $display("FAIL imm16_hold: got %h want 1234", immediate); end
  endtask

  task automatic test_modrm();
    bit got; int lat, p0, pulses, m, mc_lat; exp_t e; logic [7:0] mbyte;
    push(8'h8B); push(8'h46); push(8'hFE);
    p0 = pops; pulses = 0; m = 0; mc_lat = -1; got = 1'b0; lat = -1;
    sb.push_back(mk_exp(8'h8B, 16'hFFFE, 16'h0, 7));
    begin_insn();
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      modrm_fifo_rd_en = 1'b0;
      modrm_complete = 1'b0;
      case (m)
        0: if (modrm_start && !fifo_empty) begin modrm_fifo_rd_en = 1'b1; m = 1; end
        1: begin
          mbyte = fifo_rd_data;
          if (mbyte[7:6] == 2'b01) begin modrm_immed_start = 1'b1; modrm_immed_is_8bit = 1'b1; m = 2; end
          else if (mbyte[7:6] == 2'b10) begin modrm_immed_start = 1'b1; modrm_immed_is_8bit = 1'b0; m = 2; end
          else begin modrm_complete = 1'b1; mc_lat = cyc - t0; m = 4; end
        end
        3: begin modrm_complete = 1'b1; mc_lat = cyc - t0; m = 4; end
        default: ;
      endcase
      #1;
      if (modrm_immed_complete === 1'b1) begin
        pulses++;
        if (m == 2) begin modrm_immed_start = 1'b0; m = 3; end
      end
      if (insn_complete === 1'b1) begin got = 1'b1; lat = cyc - t0; end
    end
    modrm_immed_start = 1'b0;
    modrm_complete = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL modrm_done: got no insn_complete want pulse"); end
    else begin
      checks++;
      if ({opcode, displacement, immediate} !== {e.op, e.disp, e.imm}) begin
        errors++; $display("FAIL modrm_result: got %h/%h/%h want %h/%h/%h", opcode, displacement, immediate, e.op, e.disp, e.imm);
      end
      checks++;
      if (lat != mc_lat + 1 || lat != e.lat) begin
        errors++; $display("FAIL modrm_latency: got %0d (modrm_complete at %0d) want %0d", lat, mc_lat, e.lat);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL modrm_disp_pulse: got %0d want 1", pulses); end
    @(negedge clk); #1;
    checks++;
    if (pops - p0 != 3) begin errors++; $display("FAIL modrm_pops: got %0d want 3", pops - p0); end
  endtask

  task automatic test_empty_stall();
    bit got; int lat, viol, b0; exp_t e;
    push(8'h04);
    viol = 0; got = 1'b0; lat = -1; b0 = bad_pops;
    sb.push_back(mk_exp(8'h04, 16'h0, 16'hFF80, 8));
    begin_insn();
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc - t0 == 5) push(8'h80);
      #1;
      if (fifo_empty && fifo_rd_en) viol++;
      if (insn_complete === 1'b1) begin got = 1'b1; lat = cyc - t0; end
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL stall_done: got no insn_complete want pulse"); end
    else begin
      checks++;
      if ({opcode, displacement, immediate} !== {e.op, e.disp, e.imm}) begin
        errors++; $display("FAIL stall_result: got %h/%h/%h want %h/%h/%h", opcode, displacement, immediate, e.op, e.disp, e.imm);
      end
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL stall_latency: got %0d want %0d", lat, e.lat); end
    end
    checks++;
    if (viol != 0 || bad_pops != b0) begin
      errors++; $display("FAIL stall_empty_pop: got %0d/%0d want 0/0", viol, bad_pops - b0);
    end
  endtask

  task automatic test_flush();
    bit got; int lat, p0, spurious; exp_t e;
    push(8'hB8); push(8'h34); push(8'h12); push(8'h56);
    p0 = pops; spurious = 0;
    begin_insn();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (cyc - t0 == 3);
      #1;
      if (insn_complete === 1'b1) spurious++;
      if (cyc - t0 == 3) begin
        checks++;
        if ({modrm_clear, fifo_rd_en} !== 2'b11) begin
          errors++; $display("FAIL flush_cycle: got clear,rd_en=%b want 11", {modrm_clear, fifo_rd_en});
        end
      end
      if (cyc - t0 == 4) begin
        checks++;
        if ({busy, modrm_clear} !== 2'b00) begin
          errors++; $display("FAIL flush_idle: got busy,clear=%b want 00", {busy, modrm_clear});
        end
      end
    end
    flush = 1'b0;
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL flush_no_complete: got %0d pulses want 0", spurious); end
    checks++;
    if (pops - p0 != 3) begin errors++; $display("FAIL flush_pops: got %0d want 3", pops - p0); end
    sb.push_back(mk_exp(8'h56, 16'h0, 16'h0, 2));
    begin_insn();
    wait_insn(20, got, lat);
    e = sb.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL after_flush_done: got no insn_complete want pulse"); end
    else begin
      checks++;
      if ({opcode, displacement, immediate, lat} !== {e.op, e.disp, e.imm, e.lat}) begin
        errors++; $display("FAIL after_flush_result: got %h/%h/%h lat %0d want %h/%h/%h lat %0d",
          opcode, displacement, immediate, lat, e.op, e.disp, e.imm, e.lat);
      end
    end
  endtask

`ifdef INSN_FETCH_PREFIX_EN
  task automatic test_prefix();
    bit got; int lat; exp_t e;
    push(8'h2E); push(8'hF3); push(8'hA4);
    sb.push_back(mk_exp(8'hA4, 16'h0, 16'h0, 6));
    begin_insn();
    wait_insn(30, got, lat);
    e = sb.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL prefix_done: got no insn_complete want pulse"); end
    else begin
      checks++;
      if ({opcode, lat} !== {e.op, e.lat}) begin
        errors++; $display("FAIL prefix_opcode: got %h lat %0d want %h lat %0d", opcode, lat, e.op, e.lat);
      end
      checks++;
      if ({seg_override_valid, seg_override, lock, rep} !== {1'b1, 2'd1, 1'b0, 2'b11}) begin
        errors++; $display("FAIL prefix_fields: got v=%b seg=%0d lock=%b rep=%b want v=1 seg=1 lock=0 rep=11",
          seg_override_valid, seg_override, lock, rep);
      end
    end
  endtask
`else
  task automatic test_prefix();
    bit got; int lat; exp_t e;
    push(8'h2E);
    sb.push_back(mk_exp(8'h2E, 16'h0, 16'h0, 2));
    begin_insn();
    wait_insn(20, got, lat);
    e = sb.pop_front();
    checks++;
    if (!got) begin errors++; $display("FAIL prefix_plain_done: got no insn_complete want pulse"); end
    else begin
      checks++;
      if ({opcode, lat} !== {e.op, e.lat}) begin
        errors++; $display("FAIL prefix_plain_opcode: got %h lat %0d want %h lat %0d", opcode, lat, e.op, e.lat);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_opcode_only();
    test_imm16();
    test_modrm();
    test_empty_stall();
    test_flush();
    test_prefix();
    repeat (2) @(negedge clk);
    checks++;
    if (bad_pops != 0) begin errors++; $display("FAIL empty_pops_total: got %0d want 0", bad_pops); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
